// File: rtl/i2c_slave_regfile_if.sv
// I2C pad bundle shared by an open-drain master and the register-file responder.
// The master side drives the sensed line states; the slave side drives its pad
// outputs and active-low output enables.
interface i2c_slave_regfile_if;
  logic scl_pad_i;
  logic scl_pad_o;
  logic scl_padoen_o;
  logic sda_pad_i;
  logic sda_pad_o;
  logic sda_padoen_o;

  modport master (
    output scl_pad_i, sda_pad_i,
    input  scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o
  );

  modport slave (
    input  scl_pad_i, sda_pad_i,
    output scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o
  );
endinterface

// File: rtl/i2c_slave_regfile.sv
// I2C responder (7-bit address) with a 2**AW byte register file.
// The first byte after address+W loads the pointer; later bytes are writes.
// Reads start at the pointer. The pointer auto-increments and wraps.
// Optional macro I2C_SLAVE_FILTER_EN inserts a FILTER_LEN-deep stable filter
// after the synchronizers so that short glitches on SCL/SDA are ignored.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADR = 7'b0010_000,
  parameter int         AW        = 3
`ifdef I2C_SLAVE_FILTER_EN
  ,parameter int        FILTER_LEN = 3
`endif
) (
  input  logic                 wb_clk_i,
  input  logic                 arst_i,
  i2c_slave_regfile_if.slave   pads,
  output logic                 wr_stb_o,
  output logic [AW-1:0]        wr_adr_o,
  output logic [7:0]           wr_dat_o,
  output logic                 busy_o
);
  localparam int DEPTH = 2**AW;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK
  } state_t;

  // SCL is never stretched and SDA is open drain: only the enable moves.
  assign pads.scl_pad_o    = 1'b0;
  assign pads.scl_padoen_o = 1'b1;
  assign pads.sda_pad_o    = 1'b0;

  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic       scl_c, sda_c;
  logic       scl_prev_q, sda_prev_q;

  // Two-flop synchronizers for the asynchronous pad inputs.
  always_comb begin
    scl_sync_d = {scl_sync_q[0], pads.scl_pad_i};
    sda_sync_d = {sda_sync_q[0], pads.sda_pad_i};
  end

`ifdef I2C_SLAVE_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic [1:0]    raw_lines;
  logic [1:0]    filt_q, filt_d;
  logic [FW-1:0] fcnt_q [2];
  logic [FW-1:0] fcnt_d [2];

  assign raw_lines = {sda_sync_q[1], scl_sync_q[1]};

  // Each line flips only after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    for (int i = 0; i < 2; i++) begin
      if (raw_lines[i] == filt_q[i]) begin
        fcnt_d[i] = '0;
      end else if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
        filt_d[i] = raw_lines[i];
        fcnt_d[i] = '0;
      end else begin
        fcnt_d[i] = fcnt_q[i] + FW'(1);
      end
    end
  end

  // Filter state registers; idle lines are high.
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      filt_q <= 2'b11;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign scl_c = filt_q[0];
  assign sda_c = filt_q[1];
`else
  assign scl_c = scl_sync_q[1];
  assign sda_c = sda_sync_q[1];
`endif

  logic scl_rise, scl_fall, start_ev, stop_ev;
  assign scl_rise = scl_c & ~scl_prev_q;
  assign scl_fall = ~scl_c & scl_prev_q;
  assign start_ev = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
  assign stop_ev  = scl_c & scl_prev_q & ~sda_prev_q & sda_c;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic          oen_q, oen_d;
  logic          ack_ph_q, ack_ph_d;
  logic          rw_q, rw_d;
  logic          wr_stb_q, wr_stb_d;
  logic [AW-1:0] wr_adr_q, wr_adr_d;
  logic [7:0]    wr_dat_q, wr_dat_d;
  logic          busy_q, busy_d;
  logic [7:0]    byte_in;
  logic [7:0]    rd_byte;
  logic          byte_done;

  assign byte_in   = {shift_q[6:0], sda_c};
  assign rd_byte   = mem_q[ptr_q];
  assign byte_done = (cnt_q == 4'd7);

  // Protocol engine: line events first, then the per-state bit handling.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    ptr_d    = ptr_q;
    mem_d    = mem_q;
    oen_d    = oen_q;
    ack_ph_d = ack_ph_q;
    rw_d     = rw_q;
    wr_stb_d = 1'b0;
    wr_adr_d = wr_adr_q;
    wr_dat_d = wr_dat_q;
    busy_d   = busy_q;

    if (start_ev) begin
      state_d  = ADDR;
      cnt_d    = '0;
      busy_d   = 1'b1;
      oen_d    = 1'b1;
      ack_ph_d = 1'b0;
    end else if (stop_ev) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      oen_d    = 1'b1;
      ack_ph_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 4'd1;
          if (byte_done) begin
            cnt_d = '0;
            if (byte_in[7:1] == SLAVE_ADR) begin
              state_d = ADDR_ACK;
              rw_d    = byte_in[0];
            end else begin
              state_d = IDLE;
            end
          end
        end
        PTR: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 4'd1;
          if (byte_done) begin
            cnt_d   = '0;
            ptr_d   = byte_in[AW-1:0];
            state_d = PTR_ACK;
          end
        end
        WDATA: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 4'd1;
          if (byte_done) begin
            cnt_d        = '0;
            mem_d[ptr_q] = byte_in;
            wr_stb_d     = 1'b1;
            wr_adr_d     = ptr_q;
            wr_dat_d     = byte_in;
            ptr_d        = ptr_q + AW'(1);
            state_d      = WDATA_ACK;
          end
        end
        // First falling edge pulls SDA low for the ACK clock, the second ends it.
        ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
          if (!ack_ph_q) begin
            oen_d    = 1'b0;
            ack_ph_d = 1'b1;
          end else begin
            oen_d    = 1'b1;
            ack_ph_d = 1'b0;
            cnt_d    = '0;
            if (state_q == ADDR_ACK && rw_q) begin
              state_d = RDATA;
              shift_d = rd_byte;
              oen_d   = rd_byte[7];
            end else if (state_q == ADDR_ACK) begin
              state_d = PTR;
            end else begin
              state_d = WDATA;
            end
          end
        end
        RDATA: begin
          if (scl_rise) cnt_d = cnt_q + 4'd1;
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              oen_d   = 1'b1;
              ptr_d   = ptr_q + AW'(1);
              cnt_d   = '0;
              state_d = RACK;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oen_d   = shift_q[6];
            end
          end
        end
        RACK: begin
          if (scl_rise) begin
            if (!sda_c) begin
              ack_ph_d = 1'b1;
            end else begin
              state_d = IDLE;
              oen_d   = 1'b1;
            end
          end else if (scl_fall && ack_ph_q) begin
            ack_ph_d = 1'b0;
            state_d  = RDATA;
            shift_d  = rd_byte;
            oen_d    = rd_byte[7];
            cnt_d    = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // All state registers, including the register file, with asynchronous reset.
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      // NOTE: the register file is reset because its cleared contents are architecturally visible.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      oen_q      <= 1'b1;
      ack_ph_q   <= 1'b0;
      rw_q       <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_adr_q   <= '0;
      wr_dat_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop sees pre-edge values.
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_c;
      sda_prev_q <= sda_c;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      mem_q      <= mem_d;
      oen_q      <= oen_d;
      ack_ph_q   <= ack_ph_d;
      rw_q       <= rw_d;
      wr_stb_q   <= wr_stb_d;
      wr_adr_q   <= wr_adr_d;
      wr_dat_q   <= wr_dat_d;
      busy_q     <= busy_d;
    end
  end

  assign pads.sda_padoen_o = oen_q;
  assign wr_stb_o          = wr_stb_q;
  assign wr_adr_o          = wr_adr_q;
  assign wr_dat_o          = wr_dat_q;
  assign busy_o            = busy_q;
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: a bit-banged open-drain I2C master, a
// register-file reference model with a wrapping pointer, and strobe capture.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;
  localparam int AW = 3;
  localparam int Q  = 8;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          scl_m, sda_m;
  logic          wr_stb, busy;
  logic [AW-1:0] wr_adr;
  logic [7:0]    wr_dat;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  i2c_slave_regfile_if pads ();
  assign pads.scl_pad_i = scl_m;
  assign pads.sda_pad_i = sda_m & (pads.sda_padoen_o | pads.sda_pad_o);

  i2c_slave_regfile #(.SLAVE_ADR(7'b0010_000), .AW(AW)) dut (
    .wb_clk_i (clk),
    .arst_i   (arst_n),
    .pads     (pads),
    .wr_stb_o (wr_stb),
    .wr_adr_o (wr_adr),
    .wr_dat_o (wr_dat),
    .busy_o   (busy)
  );

  // Reference state
  logic [7:0] model_mem [8];
  int         model_ptr;
  logic [7:0] wr_buf [8];

  // Strobe capture: one entry per cycle the strobe is high
  logic [AW-1:0] stb_adr_q [$];
  logic [7:0]    stb_dat_q [$];
  always @(negedge clk) if (wr_stb) begin
    stb_adr_q.push_back(wr_adr);
    stb_dat_q.push_back(wr_dat);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_c();
    wq(Q); sda_m = 1'b1; wq(Q); scl_m = 1'b1; wq(Q); sda_m = 1'b0; wq(Q); scl_m = 1'b0;
  endtask

  task automatic stop_c();
    wq(Q); sda_m = 1'b0; wq(Q); scl_m = 1'b1; wq(Q); sda_m = 1'b1; wq(2*Q);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    wq(Q); sda_m = b; wq(Q); scl_m = 1'b1; wq(Q);
    if (glitch) begin
      scl_m = 1'b0; @(negedge clk); scl_m = 1'b1;
    end
    wq(Q); scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, input int gpos, output logic ack);
    for (int i = 0; i < 8; i++) send_bit(b[7-i], i == gpos);
    wq(Q); sda_m = 1'b1; wq(Q); scl_m = 1'b1; wq(Q);
    ack = pads.sda_pad_i;
    wq(Q); scl_m = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    wq(Q); wq(Q); scl_m = 1'b1; wq(Q);
    b = pads.sda_pad_i;
    wq(Q); scl_m = 1'b0;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    sda_m = 1'b1;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    wq(Q); sda_m = nack; wq(Q); scl_m = 1'b1; wq(2*Q); scl_m = 1'b0;
  endtask

  task automatic compare_strobes(input string tag, input logic [AW-1:0] ea[$], input logic [7:0] ed[$]);
    check({tag, "_nstb"}, stb_adr_q.size(), ea.size());
    foreach (ea[i]) begin
      if (stb_adr_q.size() != 0) begin
        check({tag, "_stb_adr"}, 32'(stb_adr_q.pop_front()), 32'(ea[i]));
        check({tag, "_stb_dat"}, 32'(stb_dat_q.pop_front()), 32'(ed[i]));
      end
    end
    stb_adr_q.delete();
    stb_dat_q.delete();
  endtask

  // Pointer byte pb, then n data bytes from wr_buf.
  task automatic do_write(input string tag, input logic [7:0] pb, input int n);
    logic          ack;
    logic [AW-1:0] ea [$];
    logic [7:0]    ed [$];
    start_c();
    check({tag, "_busy_on"}, 32'(busy), 1);
    write_byte(8'h20, -1, ack); check({tag, "_adr_ack"}, 32'(ack), 0);
    write_byte(pb, -1, ack);    check({tag, "_ptr_ack"}, 32'(ack), 0);
    model_ptr = pb % 8;
    for (int i = 0; i < n; i++) begin
      write_byte(wr_buf[i], -1, ack);
      check({tag, "_dat_ack"}, 32'(ack), 0);
      model_mem[model_ptr] = wr_buf[i];
      ea.push_back(AW'(model_ptr));
      ed.push_back(wr_buf[i]);
      model_ptr = (model_ptr + 1) % 8;
    end
    stop_c();
    check({tag, "_busy_off"}, 32'(busy), 0);
    compare_strobes(tag, ea, ed);
  endtask

  // Optionally set the pointer first (then repeated START), then read n bytes.
  task automatic do_read(input string tag, input logic set_ptr, input logic [7:0] pb, input int n);
    logic       ack;
    logic [7:0] d;
    logic [AW-1:0] ea [$];
    logic [7:0]    ed [$];
    start_c();
    if (set_ptr) begin
      write_byte(8'h20, -1, ack); check({tag, "_wadr_ack"}, 32'(ack), 0);
      write_byte(pb, -1, ack);    check({tag, "_ptr_ack"}, 32'(ack), 0);
      model_ptr = pb % 8;
      start_c();
    end
    write_byte(8'h21, -1, ack); check({tag, "_radr_ack"}, 32'(ack), 0);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, d);
      check({tag, "_rdat"}, 32'(d), 32'(model_mem[model_ptr]));
      model_ptr = (model_ptr + 1) % 8;
    end
    stop_c();
    check({tag, "_sda_rel"}, 32'(pads.sda_padoen_o), 1);
    check({tag, "_busy_off"}, 32'(busy), 0);
    compare_strobes({tag, "_nowr"}, ea, ed);
  endtask

  initial begin
    logic          ack, b;
    logic [7:0]    d, g, pb;
    int            n, gpos, k;
    logic [AW-1:0] ea [$];
    logic [7:0]    ed [$];

    for (int i = 0; i < 8; i++) model_mem[i] = 8'h00;
    model_ptr = 0;
    scl_m  = 1'b1;
    sda_m  = 1'b1;
    arst_n = 1'b0;
    wq(4);
    check("rst_sda_oen", 32'(pads.sda_padoen_o), 1);
    check("rst_scl_oen", 32'(pads.scl_padoen_o), 1);
    check("rst_busy",    32'(busy), 0);
    check("rst_stb",     32'(wr_stb), 0);
    check("rst_adr",     32'(wr_adr), 0);
    check("rst_dat",     32'(wr_dat), 0);
    arst_n = 1'b1;
    wq(4);

    // Write A5, 5A starting at pointer 1
    wr_buf[0] = 8'hA5; wr_buf[1] = 8'h5A;
    do_write("wr1", 8'h01, 2);

    // Read them back through a repeated START
    do_read("rd1", 1'b1, 8'h01, 2);

    // Random write/read-back transactions, random upper pointer bits
    for (int t = 0; t < 4; t++) begin
      pb = 8'($urandom);
      n  = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) wr_buf[i] = 8'($urandom);
      do_write("rnd_wr", pb, n);
      do_read("rnd_rd", 1'b1, pb, n);
    end

    // Wrong address: NACK, the following byte ignored, pointer untouched
    start_c();
    write_byte(8'h22, -1, ack); check("badadr_nack", 32'(ack), 1);
    write_byte(8'h00, -1, ack); check("badadr_byte_nack", 32'(ack), 1);
    stop_c();
    check("badadr_busy_off", 32'(busy), 0);
    compare_strobes("badadr", ea, ed);
    do_read("badadr_ptr", 1'b0, 8'h00, 2);

    // Pointer wrap on write and read
    wr_buf[0] = 8'h11; wr_buf[1] = 8'h22;
    do_write("wrap_wr", 8'h07, 2);
    do_read("wrap_rd", 1'b1, 8'h00, 1);
    do_read("wrap_rd7", 1'b1, 8'h07, 2);

    // One-clock low glitch on SCL during a data bit
    pb   = 8'($urandom_range(0, 7));
    d    = 8'($urandom);
    gpos = $urandom_range(0, 6);
    start_c();
    write_byte(8'h20, -1, ack); check("gl_adr_ack", 32'(ack), 0);
    write_byte(pb, -1, ack);    check("gl_ptr_ack", 32'(ack), 0);
    write_byte(d, gpos, ack);
    stop_c();
`ifdef I2C_SLAVE_FILTER_EN
    check("gl_dat_ack", 32'(ack), 0);
    g = d;
`else
    // The glitch re-samples the current bit, so the slave sees that bit twice.
    g = 8'h00; k = 0;
    for (int i = 0; i < 8; i++) begin
      if (k < 8) begin g = {g[6:0], d[7-i]}; k++; end
      if (i == gpos && k < 8) begin g = {g[6:0], d[7-i]}; k++; end
    end
`endif
    model_mem[pb] = g;
    ea.push_back(AW'(pb));
    ed.push_back(g);
    compare_strobes("glitch", ea, ed);
    ea.delete(); ed.delete();
    do_read("gl_rd", 1'b1, pb, 1);

    // Reset while the slave drives a 0 on bit 4 of a read
    wr_buf[0] = 8'hE7;
    do_write("pre_rst", 8'h04, 1);
    start_c();
    write_byte(8'h20, -1, ack); check("mrst_wadr_ack", 32'(ack), 0);
    write_byte(8'h04, -1, ack); check("mrst_ptr_ack", 32'(ack), 0);
    start_c();
    write_byte(8'h21, -1, ack); check("mrst_radr_ack", 32'(ack), 0);
    sda_m = 1'b1;
    for (int i = 0; i < 3; i++) read_bit(b);
    wq(Q); wq(Q); scl_m = 1'b1; wq(Q);
    check("mrst_driving", 32'(pads.sda_padoen_o), 0);
    arst_n = 1'b0;
    #1;
    check("mrst_sda_rel", 32'(pads.sda_padoen_o), 1);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_adr", 32'(wr_adr), 0);
    check("mrst_dat", 32'(wr_dat), 0);
    for (int i = 0; i < 8; i++) model_mem[i] = 8'h00;
    model_ptr = 0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    wq(4);
    arst_n = 1'b1;
    wq(4);
    do_read("post_rst", 1'b1, 8'h00, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
